// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard.
// Entry index layout is {file select, register index}.
package hazard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int LAT_W_DEF    = 3;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_RAW  = 2'b01;
    localparam logic [1:0] CAUSE_WAW  = 2'b10;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_FPU  = 4;

    function automatic logic [5:0] entry_idx(
        input logic       sel,
        input logic [4:0] idx
    );
        return {sel, idx};
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: cycles left until its in-flight result forwards.
// A load overrides the free-running decrement in the same cycle.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic             nz
);

    logic [LAT_W-1:0] cnt;

    // Count down to zero; a new issue reloads the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign nz = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register forwarding-latency scoreboard that stalls ID on RAW/WAW.
// Optional stall statistics counters: define STALL_STATS_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int LAT_W    = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_sel,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_sel,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_sel,
    input  logic             id_regwrite,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       stall_cause,
    output logic             busy
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      waw_cycles
`endif
);

    localparam int NE = 2 * NUM_REGS;

    logic [NE-1:0] nz;
    logic [5:0]    rs1_e;
    logic [5:0]    rs2_e;
    logic [5:0]    rd_e;
    logic          rs1_hit;
    logic          rs2_hit;
    logic          rd_hit;
    logic          raw;
    logic          waw;
    logic          accept;
    logic          wr_en;

    assign rs1_e = entry_idx(id_rs1_sel, id_rs1);
    assign rs2_e = entry_idx(id_rs2_sel, id_rs2);
    assign rd_e  = entry_idx(id_rd_sel, id_rd);

    // Hazard detection looks only at registered counters.
    always_comb begin
        rs1_hit     = 1'b0;
        rs2_hit     = 1'b0;
        rd_hit      = 1'b0;
        raw         = 1'b0;
        waw         = 1'b0;
        stall_cause = CAUSE_NONE;
        if (int'(rs1_e) < NE) rs1_hit = nz[rs1_e];
        if (int'(rs2_e) < NE) rs2_hit = nz[rs2_e];
        if (int'(rd_e) < NE)  rd_hit  = nz[rd_e];
        raw = id_valid
            & ((id_rs1_used & rs1_hit)
             | (id_rs2_used & rs2_hit));
        waw = id_valid & id_regwrite & rd_hit;
        if (raw) begin
            stall_cause = CAUSE_RAW;
        end else if (waw) begin
            stall_cause = CAUSE_WAW;
        end
    end

    assign stall  = raw | waw;
    assign accept = id_valid & ~stall & ~flush;
    assign wr_en  = accept & id_regwrite;
    assign busy   = |nz;

    // Int x0 never holds a pending result.
    assign nz[0] = 1'b0;

    for (genvar e = 1; e < NE; e++) begin : g_ent
        sb_entry #(
            .LAT_W (LAT_W)
        ) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (wr_en && (rd_e == 6'(e))),
            .lat   (id_lat),
            .nz    (nz[e])
        );
    end

`ifdef STALL_STATS_EN
    // Saturating counts of stalled cycles and WAW-caused stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            waw_cycles   <= '0;
        end else begin
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (stall_cause == CAUSE_WAW && waw_cycles != '1) begin
                waw_cycles <= waw_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side counterpart to forwarding: tracks, per architectural register (integer file and float file), how many cycles remain before an in-flight result can be forwarded.
- Stalls the ID stage when a source or destination is not yet forwardable. Covers load-use hazards, multi-cycle FPU ops and write-after-write (WAW) hazards.
- Sits beside the ID/EX pipeline register. Its stall output freezes PC, IF/ID and ID/EX, and inserts a bubble into EX.

Parameters:
- NUM_REGS, 32, registers per file; total entries = 2*NUM_REGS.
- LAT_W, 3, width of the per-entry latency counter; maximum latency is 2^LAT_W-1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source 1 index
- id_rs1_sel  in  1  source 1 file (0 int, 1 float)
- id_rs1_used  in  1  instruction reads rs1
- id_rs2  in  5  source 2 index
- id_rs2_sel  in  1  source 2 file
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  destination index
- id_rd_sel  in  1  destination file
- id_regwrite  in  1  instruction writes rd (int or float)
- id_lat  in  LAT_W  cycles after issue until the result is forwardable (0 = ALU, 1 = load, N = FPU)
- flush  in  1  branch-mispredict kill of the ID instruction
- stall  out  1  hold ID, bubble EX
- stall_cause  out  2  00 none, 01 RAW, 10 WAW
- busy  out  1  any entry has a nonzero count

Behaviour:
- State: cnt[e] of width LAT_W for e = {sel, idx}, 0..2*NUM_REGS-1. Entry {0,0} (int x0) is hard-wired to 0 and is never written.
- Reset: async on rst_n low. All cnt clear to 0, so stall=0, stall_cause=00, busy=0. Reset mid-operation discards all pending state immediately.
- Stall logic is combinational from the registered cnt only (no input-to-state feedback):
  - raw = id_valid & ((id_rs1_used & cnt[{id_rs1_sel,id_rs1}]!=0) | (id_rs2_used & cnt[{id_rs2_sel,id_rs2}]!=0))
  - waw = id_valid & id_regwrite & cnt[{id_rd_sel,id_rd}]!=0
  - stall = raw | waw
  - stall_cause = 01 if raw, else 10 if waw, else 00. RAW has priority.
- accept = id_valid & ~stall & ~flush.
- Per-cycle update, all entries: if cnt!=0, cnt <= cnt-1. Counters keep decrementing during a stall, because EX/MEM/WB keep flowing.
- On accept with id_regwrite, and the target is not int x0: cnt[{id_rd_sel,id_rd}] <= id_lat. This write overrides that entry's decrement in the same cycle. id_lat=0 writes 0, so no tracking is needed; the forwarding network covers it.
- A stalled instruction cannot write its rd entry, so WAW-stall plus issue never coincides.
- flush blocks accept only. Older in-flight counters are unaffected. stall may still assert during flush and is harmless.
- Latency semantics: issue at cycle T with id_lat=L leaves cnt=L at T+1. A dependent instruction stalls while cnt!=0, i.e. for L cycles if it arrives at T+1.
- Same-file matching only. Int x5 and float f5 are independent entries.
- busy = OR of all cnt != 0. Used by fence/CSR logic to drain.

Optional Feature:
- Macro STALL_STATS_EN.
- When defined, add the outputs stall_cycles[31:0] and waw_cycles[31:0]:
  - stall_cycles increments each cycle stall=1.
  - waw_cycles increments each cycle stall_cause=10.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- When not defined, the ports and counters are absent and the core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - LAT_W default and the NUM_REGS default;
  - stall-cause constants CAUSE_NONE/CAUSE_RAW/CAUSE_WAW;
  - latency constants LAT_ALU=0, LAT_LOAD=1, LAT_FPU=4;
  - the entry-index function {sel, idx}.
- Sub-module sb_entry: one counter with load/decrement/nonzero flag, instantiated 2*NUM_REGS-1 times via generate.

Test Plan:
- Load-use: issue load x5 (lat 1) at T; add reading x5 at T+1 -> stall=1, cause=01 at T+1 only; accept at T+2.
- FPU chain: fadd f3 (lat 4) at T; fmul reading f3 at T+1 -> stall for T+1..T+4, accept at T+5; busy falls after T+4.
- File isolation: fadd f3 (lat 4) pending; add reading int x3 -> stall=0.
- WAW: fdiv f7 (lat 7) at T; fmv writing f7 at T+1 with no reads -> stall, cause=10, until cnt[f7]=0; RAW+WAW together reports cause=01.
- x0 and flush: load writing x0 (lat 1) then reader of x0 -> no stall. Load x9 with flush=1 -> cnt[x9] stays 0, and the next reader of x9 does not stall.
- Reset mid-op: assert rst_n=0 while cnt[f3]=3 -> stall=0 and busy=0 immediately, without waiting for a clock edge. With STALL_STATS_EN, stall_cycles reads 0 after reset.
